wb_regfile: RTL
===============

// Module: wb_regfile
// PURPOSE
//  Writeback-side consumer of the MEM->WB pipeline register, fused with the architectural register file.
//  Selects the writeback value from the ALU result, the memory read data, or PC+8 (jal/jalr link).
//  Commits that value to a 32x32 register file and serves two ID-stage read ports.
//  Read ports bypass a same-cycle write, so the ID stage needs no extra WB forwarding.
//  Also counts committed writes for debug and performance monitoring.
// PARAMETERS
//  DATA_W   32  register and datapath width
//  ADDR_W   5   register index width (2**ADDR_W registers)
//  CNT_W    32  width of commit counter
// PORTS
//  clk           in   1       rising-edge clock, single clock domain
//  reset         in   1       synchronous, active-high; sampled on rising edge of clk
//  RegWrite_in   in   1       from MEM_WB: commit enable
//  MemToReg_in   in   2       from MEM_WB: 00=ALU, 01=mem data, 10=PC+8, 11=reserved
//  ReadDataMem_in in  DATA_W  from MEM_WB: load data
//  ALUResult_in  in   DATA_W  from MEM_WB: ALU result
//  RegDestination_in in ADDR_W from MEM_WB: destination index
//  PCPlus8_in    in   DATA_W  from MEM_WB: link address
//  ReadReg1_in   in   ADDR_W  ID-stage rs index
//  ReadReg2_in   in   ADDR_W  ID-stage rt index
//  ReadData1_out out  DATA_W  rs value (combinational)
//  ReadData2_out out  DATA_W  rt value (combinational)
//  WriteData_out out  DATA_W  selected writeback value (combinational), also feeds EX forwarding
//  CommitCount_out out CNT_W  number of committed register writes (registered)
// BEHAVIOUR
//  - WB mux, combinational: 00->ALUResult_in, 01->ReadDataMem_in, 10->PCPlus8_in, 11->all zeros.
//  - Commit condition: RegWrite_in=1 AND RegDestination_in!=0.
//  - Commit is a rising-edge write of WriteData_out into regs[RegDestination_in].
//  - Register 0 is hardwired to zero:
//    - writes to index 0 are dropped and do not increment CommitCount_out;
//    - reads of index 0 always return 0.
//  - Read ports, combinational, in priority order:
//    - if ReadRegN_in==0, return 0;
//    - else if the commit condition holds and RegDestination_in==ReadRegN_in, return WriteData_out (write-through bypass);
//    - else return regs[ReadRegN_in].
//  - Both read ports may hit the same index and both get the same value; both may bypass in the same cycle.
//  - CommitCount_out increments by 1 on each rising edge where the commit condition holds.
//  - CommitCount_out wraps from 2**CNT_W-1 to 0 with no flag.
//  - Latency: a committed value is visible on a read port in the same cycle via bypass, and from storage from the next cycle onward.
//  - Reset (synchronous, rising edge with reset=1):
//    - all 32 registers <= 0 and CommitCount_out <= 0;
//    - any write presented in that cycle is discarded and not counted.
//  - Reset mid-operation: the cycle after reset deasserts, every read returns 0 unless bypassed.
//  - Outputs after reset: ReadData1/2_out=0 unless bypassed; WriteData_out follows the mux; CommitCount_out=0.
//  - Stall and flush are handled upstream in MEM_WB, which zeroes RegWrite on a bubble; this block has no enable.
//  - With all-zero inputs (a bubble), nothing is committed and the counter holds.
// TESTING
//  - After reset, read r1..r31: every ReadData=0; CommitCount_out=0.
//  - RegWrite=1, MemToReg=00, ALU=0x0000_1234, Dest=5, ReadReg1=5 in the same cycle -> ReadData1=0x1234 (bypass); next cycle with RegWrite=0 -> still 0x1234; count=1.
//  - MemToReg=01 mem=0xDEAD_BEEF to r7, then MemToReg=10 PC8=0x0040_0008 to r31, then MemToReg=11 to r9 -> r7=0xDEADBEEF, r31=0x00400008, r9=0; count=3.
//  - RegWrite=1, Dest=0, ALU=0xFFFF_FFFF, ReadReg1=ReadReg2=0 -> both reads 0, r0 stays 0, count unchanged.
//  - Back-to-back writes to r3 (0x11, then 0x22) with ReadReg2=3 held -> ReadData2=0x11 then 0x22 each cycle, no stale value.
//  - Preload counter near wrap (CNT_W=4, 16 commits) -> wraps to 0; reset asserted together with a write to r4 -> r4=0 and count=0.

Source files
------------

// File: rtl/wb_regfile_if.sv
// wb_regfile_if: MEM->WB writeback bus plus ID-stage read ports for wb_regfile
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
);
  logic              RegWrite_in;
  logic [1:0]        MemToReg_in;
  logic [DATA_W-1:0] ReadDataMem_in;
  logic [DATA_W-1:0] ALUResult_in;
  logic [ADDR_W-1:0] RegDestination_in;
  logic [DATA_W-1:0] PCPlus8_in;
  logic [ADDR_W-1:0] ReadReg1_in;
  logic [ADDR_W-1:0] ReadReg2_in;
  logic [DATA_W-1:0] ReadData1_out;
  logic [DATA_W-1:0] ReadData2_out;
  logic [DATA_W-1:0] WriteData_out;
  logic [CNT_W-1:0]  CommitCount_out;
  modport master (
    output RegWrite_in, MemToReg_in, ReadDataMem_in, ALUResult_in,
           RegDestination_in, PCPlus8_in, ReadReg1_in, ReadReg2_in,
    input  ReadData1_out, ReadData2_out, WriteData_out, CommitCount_out
  );
  modport slave (
    input  RegWrite_in, MemToReg_in, ReadDataMem_in, ALUResult_in,
           RegDestination_in, PCPlus8_in, ReadReg1_in, ReadReg2_in,
    output ReadData1_out, ReadData2_out, WriteData_out, CommitCount_out
  );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: writeback mux fused with a 32x32 register file, bypassed read ports and commit counter
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input logic         clk,
  input logic         reset,
  wb_regfile_if.slave bus
);
  localparam int NREG = 2 ** ADDR_W;
  logic [DATA_W-1:0] regs [NREG];
  logic [CNT_W-1:0]  count;
  logic              commit;
  // Writeback select; the reserved encoding yields zero so a bad decode commits nothing harmful
  always_comb begin
    bus.WriteData_out = bus.MemToReg_in == 2'b00 ? bus.ALUResult_in :
                        bus.MemToReg_in == 2'b01 ? bus.ReadDataMem_in :
                        bus.MemToReg_in == 2'b10 ? bus.PCPlus8_in : '0;
    commit = bus.RegWrite_in && bus.RegDestination_in != '0;
  end
  // Read ports: r0 is zero, then same-cycle write-through, then storage
  always_comb begin
    bus.ReadData1_out = bus.ReadReg1_in == '0 ? '0 :
                        commit && bus.RegDestination_in == bus.ReadReg1_in ? bus.WriteData_out :
                        regs[bus.ReadReg1_in];
    bus.ReadData2_out = bus.ReadReg2_in == '0 ? '0 :
                        commit && bus.RegDestination_in == bus.ReadReg2_in ? bus.WriteData_out :
                        regs[bus.ReadReg2_in];
  end
  // Commit and count; reset wins over any write presented in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      count <= '0;
    end else if (commit) begin
      regs[bus.RegDestination_in] <= bus.WriteData_out;
      count <= count + CNT_W'(1);
    end
  end
  assign bus.CommitCount_out = count;
endmodule
